// File: rtl/list_fold_sum.sv
// rtl/list_fold_sum.sv - pulls a req/ack/eol list element by element and folds it into a sum
module list_fold_sum #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter int SIGNED    = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ready,
    output logic                 list_req,
    input  logic                 list_ack,
    input  logic                 list_eol,
    input  logic [WIDTH-1:0]     list_value,
    output logic [ACC_WIDTH-1:0] result,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 done,
    output logic                 error,
    output logic                 overflow
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        GAP,
        DONE,
        ERR
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic [ACC_WIDTH-1:0] ext_value;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] sum;
    logic                 add_ovf;
    logic                 count_full;

    // Widen the element and form the next sum plus its overflow flag
    always_comb begin
        ext_value = '0;
        if (SIGNED != 0) begin
            ext_value = ACC_WIDTH'($signed(list_value));
        end else begin
            ext_value = ACC_WIDTH'(list_value);
        end
        sum_full   = {1'b0, result} + {1'b0, ext_value};
        sum        = sum_full[ACC_WIDTH-1:0];
        count_full = &count;
        if (SIGNED != 0) begin
            add_ovf = (result[ACC_WIDTH-1] == ext_value[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != result[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum_full[ACC_WIDTH];
        end
    end

    // Element-pull FSM; list_req/done/error are registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            list_req <= 1'b0;
            result   <= '0;
            count    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else if (!ready) begin
            state    <= IDLE;
            timer    <= '0;
            list_req <= 1'b0;
            result   <= '0;
            count    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    // eol is trusted only here: req is low and the last ack is at least a cycle old
                    if (list_eol) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= REQ;
                        list_req <= 1'b1;
                        timer    <= '0;
                    end
                end
                REQ: begin
                    // an ack on the last permitted cycle still wins over the timeout
                    if (list_ack) begin
                        result   <= sum;
                        state    <= GAP;
                        list_req <= 1'b0;
                        if (!count_full) begin
                            count <= count + 1'b1;
                        end
                        if (add_ovf || count_full) begin
                            overflow <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state    <= ERR;
                        list_req <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    // one low cycle so upstream sees a fresh rising edge on the next request
                    state <= CHECK;
                end
                DONE: begin
                    state <= DONE;
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= IDLE;
                    list_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
